// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store target for the core.
// Byte-addressed little-endian array with func3 sizing and error flags.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_we                1 = store, 0 = load
//   req_addr              byte address, DM_ADDRESS bits
//   req_wdata             store data (low byte/half for SB/SH)
//   req_func3             000 B, 001 H, 010 W, 100 BU, 101 HU
//   resp_valid/resp_ready response handshake, LAT cycles after accept
//   resp_rdata            extended load data; 0 for stores and errors
//   resp_err              misaligned access or illegal func3
module dmem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LAT        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_func3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err
);

  localparam int WA    = DM_ADDRESS - 2;
  localparam int WORDS = 2 ** WA;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic [1:0]        a_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] word_q;
  logic              err_q;

  logic [DATA_W-1:0] mem_q [WORDS];

  logic          accept;
  logic          err_now;
  logic [WA-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wdat;

  function automatic logic access_err(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic e;
    case (f3)
      3'b000:  e = 1'b0;
      3'b001:  e = a[0];
      3'b010:  e = (a != 2'b00);
      3'b100:  e = we;
      3'b101:  e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready & ~reset;
  assign widx      = req_addr[DM_ADDRESS-1:2];
  assign err_now   = access_err(req_we, req_func3,
                                req_addr[1:0]);

  // Lane enables and lane-replicated data for stores.
  always_comb begin
    be   = 4'b1111;
    wdat = req_wdata;
    case (req_func3)
      3'b000: begin
        be   = 4'b0001 << req_addr[1:0];
        wdat = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        be   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{req_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err_now) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  // Counter holds 1 on the accept edge, so RESP is
  // entered exactly LAT edges after acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = 4'd1;
          state_d = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'(LAT - 1)) state_d = RESP;
        else cnt_d = cnt_q + 4'd1;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      a_q     <= 2'b00;
      f3_q    <= 3'b000;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= req_we;
        a_q    <= req_addr[1:0];
        f3_q   <= req_func3;
        word_q <= mem_q[widx];
        err_q  <= err_now;
      end
    end
  end

  logic [7:0]        bsel;
  logic [15:0]       hsel;
  logic [DATA_W-1:0] ext;

  assign bsel = word_q[{a_q, 3'b000} +: 8];
  assign hsel = a_q[1] ? word_q[31:16] : word_q[15:0];

  always_comb begin
    ext = '0;
    case (f3_q)
      3'b000:  ext = {{24{bsel[7]}}, bsel};
      3'b001:  ext = {{16{hsel[15]}}, hsel};
      3'b010:  ext = word_q;
      3'b100:  ext = {24'd0, bsel};
      3'b101:  ext = {16'd0, hsel};
      default: ext = '0;
    endcase
  end

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q)
                      ? ext : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LAT=2 and LAT=3 instances,
// directed steps with a scoreboard queue of expected responses.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic [1:0]  reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [8:0]  req_addr [2];
  logic [31:0] req_wdata [2];
  logic [2:0]  req_func3 [2];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [1:0]  resp_err;
  logic [31:0] rdata0, rdata1;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LAT(2)) u2 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_func3(req_func3[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(rdata0), .resp_err(resp_err[0])
  );

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LAT(3)) u3 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_func3(req_func3[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(rdata1), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(int s);
    return (s == 0) ? rdata0 : rdata1;
  endfunction

  function automatic int lat_of(int s);
    return (s == 0) ? 2 : 3;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(int s, bit we, logic [8:0] a,
                       logic [31:0] d, logic [2:0] f);
    req_we[s]    = we;
    req_addr[s]  = a;
    req_wdata[s] = d;
    req_func3[s] = f;
    req_valid[s] = 1'b1;
  endtask

  task automatic xact(string tag, int s, bit we,
                      logic [8:0] a, logic [31:0] d,
                      logic [2:0] f, logic [31:0] er,
                      bit ee);
    exp_t e;
    int n;
    @(negedge clk);
    drive(s, we, a, d, f);
    chk({tag, "_rdy"}, req_ready[s], 1'b1);
    @(posedge clk);
    e.rdata = er;
    e.err   = ee;
    sb.push_back(e);
    @(negedge clk);
    req_valid[s] = 1'b0;
    n = 1;
    while (!resp_valid[s] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat_of(s));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, rd(s), e.rdata);
      chk({tag, "_err"}, resp_err[s], e.err);
    end
    resp_ready[s] = 1'b1;
    @(negedge clk);
    resp_ready[s] = 1'b0;
    chk({tag, "_vdrop"}, resp_valid[s], 1'b0);
    chk({tag, "_idle"}, req_ready[s], 1'b1);
  endtask

  initial begin
    exp_t e;
    int n;
    reset      = 2'b11;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_we     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_func3[i] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 2'b00;
    for (int i = 0; i < 2; i++) begin
      chk("rst_rdy", req_ready[i], 1'b1);
      chk("rst_val", resp_valid[i], 1'b0);
      chk("rst_rd", rd(i), 32'h0);
      chk("rst_err", resp_err[i], 1'b0);
    end

    xact("sw10", 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 0);
    xact("lw10", 0, 0, 9'h010, 0, 3'b010, 32'hDEADBEEF, 0);

    xact("lb13", 0, 0, 9'h013, 0, 3'b000, 32'hFFFFFFDE, 0);
    xact("lbu13", 0, 0, 9'h013, 0, 3'b100, 32'h000000DE, 0);
    xact("lh12", 0, 0, 9'h012, 0, 3'b001, 32'hFFFFDEAD, 0);
    xact("lhu10", 0, 0, 9'h010, 0, 3'b101, 32'h0000BEEF, 0);
    xact("lb10", 0, 0, 9'h010, 0, 3'b000, 32'hFFFFFFEF, 0);
    xact("lbu11", 0, 0, 9'h011, 0, 3'b100, 32'h000000BE, 0);

    xact("sb11", 0, 1, 9'h011, 32'hFFFFFF55, 3'b000, 0, 0);
    xact("lw_a", 0, 0, 9'h010, 0, 3'b010, 32'hDEAD55EF, 0);
    xact("sh12", 0, 1, 9'h012, 32'hFFFF1234, 3'b001, 0, 0);
    xact("lw_b", 0, 0, 9'h010, 0, 3'b010, 32'h123455EF, 0);

    xact("lw12e", 0, 0, 9'h012, 0, 3'b010, 0, 1);
    xact("sh13e", 0, 1, 9'h013, 32'hAAAAAAAA, 3'b001, 0, 1);
    xact("f011e", 0, 0, 9'h010, 0, 3'b011, 0, 1);
    xact("lh11e", 0, 0, 9'h011, 0, 3'b001, 0, 1);
    xact("sbue", 0, 1, 9'h010, 32'h77777777, 3'b100, 0, 1);
    xact("lw_c", 0, 0, 9'h010, 0, 3'b010, 32'h123455EF, 0);

    xact("sw1fc", 0, 1, 9'h1FC, 32'hCAFEF00D, 3'b010, 0, 0);
    xact("lhu1fe", 0, 0, 9'h1FE, 0, 3'b101, 32'h0000CAFE, 0);

    xact("sw40", 1, 1, 9'h040, 32'h11223344, 3'b010, 0, 0);
    @(negedge clk);
    drive(1, 0, 9'h040, 0, 3'b010);
    @(posedge clk);
    e.rdata = 32'h11223344;
    e.err   = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    drive(1, 1, 9'h040, 32'hFFFFFFFF, 3'b010);
    n = 1;
    while (!resp_valid[1] && n < 40) begin
      chk("stall_wait_rdy", req_ready[1], 1'b0);
      @(negedge clk);
      n++;
    end
    chk("stall_lat", n, 3);
    if (sb.size() == 0) begin
      chk("stall_sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      repeat (4) begin
        chk("stall_val", resp_valid[1], 1'b1);
        chk("stall_rd", rdata1, e.rdata);
        chk("stall_err", resp_err[1], e.err);
        chk("stall_rdy", req_ready[1], 1'b0);
        @(negedge clk);
      end
    end
    req_valid[1]  = 1'b0;
    resp_ready[1] = 1'b1;
    @(negedge clk);
    resp_ready[1] = 1'b0;
    chk("stall_vdrop", resp_valid[1], 1'b0);
    chk("stall_idle", req_ready[1], 1'b1);
    xact("lw40", 1, 0, 9'h040, 0, 3'b010, 32'h11223344, 0);

    xact("sw20", 0, 1, 9'h020, 32'hA5A5A5A5, 3'b010, 0, 0);
    @(negedge clk);
    drive(0, 0, 9'h020, 0, 3'b010);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    reset[0]     = 1'b1;
    @(negedge clk);
    reset[0] = 1'b0;
    chk("mid_rst_val", resp_valid[0], 1'b0);
    chk("mid_rst_rdy", req_ready[0], 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_noresp", resp_valid[0], 1'b0);
    end
    xact("lw20", 0, 0, 9'h020, 0, 3'b010, 32'hA5A5A5A5, 0);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
